// File: rtl/bcd_pkg.sv
// Shared BCD definitions for both conversion directions (binary<->BCD).
// Contents: digit width and adjust constants, FSM state type for the
// BCD-to-binary converter, and a helper that flags non-decimal digits.
package bcd_pkg;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] ADJ_THR = 4'd8;
    localparam logic [3:0] ADJ_VAL = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd2bin_state_t;

    // A nibble of 0xA..0xF is not a decimal digit.
    function automatic logic digit_invalid(input logic [DIGIT_W-1:0] d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit correction step of reverse double-dabble.
// After a right shift, a digit that received a bit from the digit above
// has gained 8 where it should have gained 5, so 3 is taken back off.
// Ports:
//   d_in   digit after the shift
//   d_out  corrected digit
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] d_in,
    output logic [DIGIT_W-1:0] d_out
);

    assign d_out = (d_in >= ADJ_THR) ? d_in - ADJ_VAL : d_in;

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter (reverse double-dabble), one bit per clock.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    conversion request, honoured only when idle
//   bcd_in   DIGITS packed BCD digits, digit 0 in the low nibble
//   busy     high while a conversion is in flight (SHIFT or DONE)
//   done     one-cycle pulse marking binario/erro as freshly valid
//   erro     a captured digit was not decimal; result forced to zero
//   binario  zero-extended binary result, held until the next done
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 7,
    parameter int BIN_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
    output logic                      busy,
    output logic                      done,
    output logic                      erro,
    output logic [BIN_W-1:0]          binario
);

    localparam int             BCD_W = DIGIT_W * DIGITS;
    localparam int             CNT_W = $clog2(BCD_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BCD_W - 1);

    bcd2bin_state_t     state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BCD_W-1:0]   bcd_sr_q, bcd_sr_d;
    logic [BCD_W-1:0]   bin_sr_q, bin_sr_d;
    logic               err_q, err_d;
    logic               erro_q, erro_d;
    logic [BIN_W-1:0]   binario_q, binario_d;

    // One right shift across the concatenated {bcd, bin} registers.
    logic [2*BCD_W-1:0] cat_shift;
    logic [BCD_W-1:0]   bcd_shift;
    logic [BCD_W-1:0]   bin_shift;
    logic [BCD_W-1:0]   bcd_adj;

    assign cat_shift = {bcd_sr_q, bin_sr_q} >> 1;
    assign bcd_shift = cat_shift[2*BCD_W-1:BCD_W];
    assign bin_shift = cat_shift[BCD_W-1:0];

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        bcd_digit_adj u_adj (
            .d_in  (bcd_shift[k*DIGIT_W +: DIGIT_W]),
            .d_out (bcd_adj[k*DIGIT_W +: DIGIT_W])
        );
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        bcd_sr_d  = bcd_sr_q;
        bin_sr_d  = bin_sr_q;
        err_d     = err_q;
        erro_d    = erro_q;
        binario_d = binario_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SHIFT;
                    bcd_sr_d = bcd_in;
                    bin_sr_d = '0;
                    count_d  = '0;
                    err_d    = 1'b0;
                    for (int k = 0; k < DIGITS; k++) begin
                        if (digit_invalid(bcd_in[k*DIGIT_W +: DIGIT_W])) err_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                bcd_sr_d = bcd_adj;
                bin_sr_d = bin_shift;
                count_d  = count_q + 1'b1;
                // Outputs are loaded from the final shift directly so that
                // no partial result is ever visible on binario.
                if (count_q == LAST_CNT) begin
                    state_d   = DONE;
                    binario_d = err_q ? '0 : BIN_W'(bin_shift);
                    erro_d    = err_q;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            bcd_sr_q  <= '0;
            bin_sr_q  <= '0;
            err_q     <= 1'b0;
            erro_q    <= 1'b0;
            binario_q <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            bcd_sr_q  <= bcd_sr_d;
            bin_sr_q  <= bin_sr_d;
            err_q     <= err_d;
            erro_q    <= erro_d;
            binario_q <= binario_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign erro    = erro_q;
    assign binario = binario_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
module tb_bcd_to_bin;

    localparam int DIGITS = 7;
    localparam int BIN_W  = 32;
    localparam int BCD_W  = 4 * DIGITS;
    localparam int LAT    = 4 * DIGITS;  // posedges from accept edge to the edge that raises done

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic             err;
        int               acc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [BCD_W-1:0] bcd_in = '0;
    logic             busy, done, erro;
    logic [BIN_W-1:0] binario;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t sb[$];

    bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .erro    (erro),
        .binario (binario)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_done) begin
                chk("done_width", {63'd0, done}, 64'd0);
                chk("busy_after_done", {63'd0, busy}, 64'd0);
            end
            if (done) begin
                chk("busy_in_done", {63'd0, busy}, 64'd1);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("binario", {32'd0, binario}, {32'd0, e.bin});
                    chk("erro", {63'd0, erro}, {63'd0, e.err});
                    chk("latency", 64'(cyc - e.acc), 64'(LAT));
                end
            end
            prev_done <= done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    // Waits for idle, presents one request, returns #1 after the accepting edge.
    task automatic issue(input logic [BCD_W-1:0] bcd, input logic [BIN_W-1:0] eb, input logic ee);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy) chk("idle_timeout", 64'd1, 64'd0);
        start  = 1'b1;
        bcd_in = bcd;
        @(posedge clk);
        #1;
        start  = 1'b0;
        e.bin  = eb;
        e.err  = ee;
        e.acc  = cyc;
        sb.push_back(e);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_erro", {63'd0, erro}, 64'd0);
        chk("rst_binario", {32'd0, binario}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors
        issue(28'h0000000, 32'd0, 1'b0);
        issue(28'h0001234, 32'd1234, 1'b0);
        issue(28'h9999999, 32'd9999999, 1'b0);
        issue(28'h0000001, 32'd1, 1'b0);        // back-to-back with previous
        issue(28'h00000A5, 32'd0, 1'b1);
        issue(28'h0000807, 32'd807, 1'b0);      // clears erro
        issue(28'hF000000, 32'd0, 1'b1);        // invalid top digit
        issue(28'h1000000, 32'd1000000, 1'b0);

        // Start pulses and bcd_in changes while busy are ignored
        issue(28'h0054321, 32'd54321, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            start  = (i == 5 || i == 10);
            bcd_in = BCD_W'($urandom);
        end
        start = 1'b0;

        // Reset in mid-conversion clears outputs immediately
        issue(28'h0000777, 32'd777, 1'b0);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_erro", {63'd0, erro}, 64'd0);
        chk("midrst_binario", {32'd0, binario}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(28'h0000042, 32'd42, 1'b0);

        // Random valid digits against a decimal-weight model
        for (int r = 0; r < 8; r++) begin
            logic [BCD_W-1:0] b;
            logic [BIN_W-1:0] v;
            logic [BIN_W-1:0] w;
            b = '0;
            v = '0;
            w = 32'd1;
            for (int k = 0; k < DIGITS; k++) begin
                logic [3:0] d;
                d = 4'($urandom_range(0, 9));
                b[k*4 +: 4] = d;
                v = v + BIN_W'(d) * w;
                w = w * 32'd10;
            end
            issue(b, v, 1'b0);
        end

        // Drain
        for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
